// File: rtl/codec_dac_tx.sv
// I2S transmitter toward the codec DAC, slaved to the codec's BCLK and DACLRCK.
// A one-deep L/R holding register with valid/ready feeds each frame; an empty register at frame start sends silence.
module codec_dac_tx #(
   parameter int LEADING_BITS  = 1,
   parameter int DATA_BITS     = 16,
   parameter int TRAILING_BITS = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 codec_aud_bclk_i,
   input  logic                 codec_aud_daclrck_i,
   output logic                 codec_aud_dacdat_o,
   input  logic [DATA_BITS-1:0] tx_sample_L_i,
   input  logic [DATA_BITS-1:0] tx_sample_R_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 tx_frame_o,
   output logic                 tx_underrun_o
);
   localparam int SLOT = LEADING_BITS + DATA_BITS + TRAILING_BITS;
   localparam int CW   = $clog2(SLOT + 1);

   typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

   state_t               state_reg, state_next;
   logic [2:0]           bclk_sync_reg;
   logic [1:0]           lrck_sync_reg;
   logic                 lrck_prev_reg;
   logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [DATA_BITS-1:0] tx_r_reg, tx_r_next;
   logic [DATA_BITS-1:0] hold_l_reg, hold_r_reg;
   logic                 hold_full_reg, hold_full_next;
   logic                 dacdat_reg, dacdat_next;
   logic                 frame_reg, underrun_reg;

   logic                 bclk_fall, lrck_cur, lrck_fell, lrck_rose, accept;
   logic [DATA_BITS-1:0] word;
   logic [CW-1:0]        cnt_eff;

   // BCLK and LRCK share the same two-flop depth so they stay phase-aligned.
   assign bclk_fall = bclk_sync_reg[2] & ~bclk_sync_reg[1];
   assign lrck_cur  = lrck_sync_reg[1];
   assign lrck_fell = bclk_fall & lrck_prev_reg & ~lrck_cur;
   assign lrck_rose = bclk_fall & ~lrck_prev_reg & lrck_cur;
   assign accept    = tx_valid_i & ~hold_full_reg;

   assign codec_aud_dacdat_o = dacdat_reg;
   assign tx_ready_o         = ~hold_full_reg;
   assign tx_frame_o         = frame_reg;
   assign tx_underrun_o      = underrun_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= WAIT_SYNC;
         bclk_sync_reg <= '0;
         lrck_sync_reg <= '0;
         lrck_prev_reg <= 1'b0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         tx_r_reg      <= '0;
         hold_l_reg    <= '0;
         hold_r_reg    <= '0;
         hold_full_reg <= 1'b0;
         dacdat_reg    <= 1'b0;
         frame_reg     <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bclk_sync_reg <= {bclk_sync_reg[1:0], codec_aud_bclk_i};
         lrck_sync_reg <= {lrck_sync_reg[0], codec_aud_daclrck_i};
         if (bclk_fall) begin
            lrck_prev_reg <= lrck_cur;
         end
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         tx_r_reg      <= tx_r_next;
         hold_full_reg <= hold_full_next;
         dacdat_reg    <= dacdat_next;
         frame_reg     <= lrck_fell;
         underrun_reg  <= lrck_fell & ~hold_full_reg;
         if (accept) begin
            hold_l_reg <= tx_sample_L_i;
            hold_r_reg <= tx_sample_R_i;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      tx_r_next      = tx_r_reg;
      hold_full_next = hold_full_reg;
      dacdat_next    = dacdat_reg;
      word           = shift_reg;
      cnt_eff        = bit_cnt_reg;

      // A pair arriving in the frame-start cycle is kept for the next frame, never bypassed.
      if (accept) begin
         hold_full_next = 1'b1;
      end else if (lrck_fell && hold_full_reg) begin
         hold_full_next = 1'b0;
      end

      if (lrck_fell) begin
         state_next = RUN;
         tx_r_next  = hold_full_reg ? hold_r_reg : '0;
      end

      if (bclk_fall && (state_reg == RUN || lrck_fell)) begin
         if (lrck_fell) begin
            word    = hold_full_reg ? hold_l_reg : '0;
            cnt_eff = '0;
         end else if (lrck_rose) begin
            word    = tx_r_reg;
            cnt_eff = '0;
         end else if (bit_cnt_reg < CW'(SLOT)) begin
            cnt_eff = bit_cnt_reg + 1'b1;
         end
         bit_cnt_next = cnt_eff;
         shift_next   = word;
         dacdat_next  = 1'b0;
         if (cnt_eff >= CW'(LEADING_BITS) && cnt_eff < CW'(LEADING_BITS + DATA_BITS)) begin
            dacdat_next = word[DATA_BITS-1];
            shift_next  = word << 1;
         end
      end
   end
endmodule
